// File: rtl/rx_pkt_reader_pkg.sv
// rtl/rx_pkt_reader_pkg.sv - shared types and constants for the RX packet buffer reader
package rx_pkt_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    GAP
  } state_t;

  localparam int SKID_DEPTH = 3;

  // Completion status codes, shared with the packet generator
  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_BAD_LEN = 2'd1;

endpackage

// File: rtl/rx_pkt_skid_fifo.sv
// rtl/rx_pkt_skid_fifo.sv - 3-entry shift-register skid FIFO of {data, sop, eop}
import rx_pkt_reader_pkg::*;

module rx_pkt_skid_fifo #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] push_data,
  input  logic                 push_sop,
  input  logic                 push_eop,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] head_data,
  output logic                 head_sop,
  output logic                 head_eop,
  output logic                 head_valid,
  output logic [1:0]           occ
);

  logic [DATAWIDTH+1:0] entry_q [SKID_DEPTH];
  logic [1:0]           wr_idx;

  // Entry 0 is always the head; a pop shifts everything down one slot
  assign wr_idx = pop ? (occ - 2'd1) : occ;

  always_ff @(posedge clock) begin
    if (reset) begin
      occ <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) entry_q[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < SKID_DEPTH - 1; i++) entry_q[i] <= entry_q[i+1];
      end
      if (push) entry_q[wr_idx] <= {push_data, push_sop, push_eop};
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign {head_data, head_sop, head_eop} = entry_q[0];
  assign head_valid = (occ != 2'd0);

endmodule

// File: rtl/rx_pkt_reader.sv
// rtl/rx_pkt_reader.sv - replays a packet from the RX buffer RAM as a byte stream with inter-frame gap
import rx_pkt_reader_pkg::*;

module rx_pkt_reader #(
  parameter int DATAWIDTH  = 8,
  parameter int ADDRWIDTH  = 11,
  parameter int ADDRDEPTH  = 2048,
  parameter int IFG_CYCLES = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] start_addr,
  input  logic [ADDRWIDTH:0]   pkt_len,
  output logic [ADDRWIDTH-1:0] rdaddress,
  input  logic [DATAWIDTH-1:0] q,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [ADDRWIDTH:0]   MAX_LEN   = (ADDRWIDTH + 1)'(ADDRDEPTH);

  state_t             state, next_state;
  logic [ADDRWIDTH:0] rd_remaining, out_remaining;
  logic [15:0]        gap_cnt;
  logic               inflight, first_pending, done_q;
  logic [1:0]         status_q, fifo_occ;
  logic               len_ok, accept, reject, issue, pop, last_hs;

  assign len_ok  = (pkt_len != '0) && (pkt_len <= MAX_LEN);
  assign pop     = out_valid && out_ready;
  assign last_hs = pop && (out_remaining == (ADDRWIDTH + 1)'(1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start && len_ok) begin
          accept     = 1'b1;
          next_state = READ;
        end else if (start) begin
          reject = 1'b1;
        end
      end
      READ: begin
        // Bytes in the FIFO plus the one in the RAM pipe never exceed the skid depth
        issue = (rd_remaining != '0) &&
                (({1'b0, fifo_occ} + {2'b0, inflight}) < 3'(SKID_DEPTH));
        if (issue && rd_remaining == (ADDRWIDTH + 1)'(1)) next_state = DRAIN;
      end
      DRAIN: if (last_hs) next_state = GAP;
      GAP:   if (gap_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdaddress     <= '0;
      rd_remaining  <= '0;
      out_remaining <= '0;
      gap_cnt       <= '0;
      inflight      <= 1'b0;
      first_pending <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= STAT_OK;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (accept) begin
        rdaddress     <= start_addr;
        rd_remaining  <= pkt_len;
        out_remaining <= pkt_len;
        first_pending <= 1'b1;
      end
      if (issue) begin
        rdaddress    <= (rdaddress == LAST_ADDR) ? '0 : rdaddress + 1'b1;
        rd_remaining <= rd_remaining - 1'b1;
      end
      if (inflight) first_pending <= 1'b0;
      if (pop) out_remaining <= out_remaining - 1'b1;
      if (reject) begin
        done_q   <= 1'b1;
        status_q <= STAT_BAD_LEN;
      end
      if (state == DRAIN && last_hs) begin
        done_q   <= 1'b1;
        status_q <= STAT_OK;
        gap_cnt  <= 16'(IFG_CYCLES);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // The byte landing now is the last one once no reads remain to be issued
  rx_pkt_skid_fifo #(.DATAWIDTH(DATAWIDTH)) u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (inflight),
    .push_data  (q),
    .push_sop   (first_pending),
    .push_eop   (rd_remaining == '0),
    .pop        (pop),
    .head_data  (out_data),
    .head_sop   (out_sop),
    .head_eop   (out_eop),
    .head_valid (out_valid),
    .occ        (fifo_occ)
  );

  assign busy = (state != IDLE);
  assign done = done_q;
  assign err  = done_q && (status_q == STAT_BAD_LEN);

endmodule

// File: tb/tb_rx_pkt_reader.sv
// tb/tb_rx_pkt_reader.sv - self-checking bench for rx_pkt_reader with RAM model and stream scoreboard
module tb_rx_pkt_reader;

  localparam int DW = 8;
  localparam int AW = 11;
  localparam int AD = 2048;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   pkt_len = '0;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop, busy, done, err;
  logic          out_ready = 1'b1;

  logic [DW-1:0] mem [0:AD-1];

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  beat_t expq[$];
  beat_t bq;
  int    total = 0;
  int    bad = 0;
  int    beats = 0;
  int    done_cnt = 0;
  bit    rej_window = 0;

  logic       pv = 0, pr = 0, ps = 0, pe = 0, prev_eop_hs = 0;
  logic [7:0] pd = 0;

  int            p_first, p_eop, p_done, p_idle;
  logic [7:0]    p_firstd, p_lastb;
  logic          p_lasts;
  logic [AW-1:0] ra [0:15];

  rx_pkt_reader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .pkt_len    (pkt_len),
    .rdaddress  (rdaddress),
    .q          (q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) q <= mem[rdaddress];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted byte must be the next one the model predicts
  always @(negedge clock) begin
    if (reset) begin
      pv = 0;
      prev_eop_hs = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", {31'b0, out_valid}, 1);
        chk("hold_beat", {out_data, out_sop, out_eop}, {pd, ps, pe});
      end
      if (!rej_window) begin
        chk("done_vs_eop", {31'b0, done}, {31'b0, prev_eop_hs});
        chk("err_quiet", {31'b0, err}, 0);
      end
      if (done) done_cnt++;
      prev_eop_hs = 0;
      if (out_valid && out_ready) begin
        chk("beat_expected", {31'b0, expq.size() != 0}, 1);
        if (expq.size() != 0) begin
          bq = expq.pop_front();
          chk("beat", {out_data, out_sop, out_eop}, {bq.d, bq.s, bq.e});
        end
        beats++;
        prev_eop_hs = out_eop;
      end
      pv = out_valid; pr = out_ready; pd = out_data; ps = out_sop; pe = out_eop;
    end
  end

  task automatic send(input int addr, input int len, input bit model);
    @(posedge clock); #1;
    start = 1'b1;
    start_addr = 11'(addr);
    pkt_len = 12'(len);
    if (model) begin
      for (int i = 0; i < len; i++) begin
        bq.d = mem[(addr + i) % AD];
        bq.s = (i == 0);
        bq.e = (i == len - 1);
        expq.push_back(bq);
      end
    end
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Cycle 0 is the one in which start is sampled; timings are recorded relative to it
  task automatic play(input int addr, input int len, input bit rnd, input int inj);
    int c;
    c = 0;
    p_first = -1; p_eop = -1; p_done = -1; p_idle = -1;
    p_firstd = 0; p_lastb = 0; p_lasts = 0;
    send(addr, len, 1);
    while (c < 400 && p_idle < 0) begin
      @(negedge clock);
      c++;
      if (c < 16) ra[c] = rdaddress;
      if (out_valid && p_first < 0) begin p_first = c; p_firstd = out_data; end
      if (out_valid && out_ready && out_eop) begin p_eop = c; p_lastb = out_data; p_lasts = out_sop; end
      if (done && p_done < 0) p_done = c;
      if (!busy && p_idle < 0) p_idle = c;
      @(posedge clock); #1;
      out_ready = rnd ? ((c % 12 >= 7) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      start = (inj > 0) && (c == inj || (p_done > 0 && c == p_done + 2));
      if (start) begin start_addr = '0; pkt_len = 12'd3; end
    end
    out_ready = 1'b1;
    start = 1'b0;
    chk("play_finished", {31'b0, p_idle > 0}, 1);
  endtask

  task automatic reject(input int len);
    rej_window = 1;
    send(7, len, 0);
    @(negedge clock);
    chk("rej_pulse", {28'b0, done, err, busy, out_valid}, 4'b1100);
    @(negedge clock);
    chk("rej_clear", {28'b0, done, err, busy, out_valid}, 4'b0000);
    rej_window = 0;
    repeat (4) begin
      @(negedge clock);
      chk("rej_quiet", {30'b0, out_valid, busy}, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, d0;
    int wexp [8];
    wexp = '{2044, 2045, 2046, 2047, 0, 1, 2, 3};
    for (int i = 0; i < AD; i++) mem[i] = (i < 64) ? 8'(i) : 8'((i * 13 + 7) % 256);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outs", {7'b0, rdaddress, out_valid, out_sop, out_eop, out_data, busy, done, err}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 64 bytes holding data=addr
    play(0, 64, 0, 0);
    chk("t1_first_cycle", p_first, 3);
    chk("t1_first_byte", {23'b0, p_firstd}, 8'h00);
    chk("t1_eop_cycle", p_eop, 66);
    chk("t1_last_byte", {24'b0, p_lastb}, 8'h3f);
    chk("t1_done_cycle", p_done, 67);
    chk("t1_idle_cycle", p_idle, 80);

    // address wrap
    play(2044, 8, 0, 0);
    for (int k = 0; k < 8; k++) chk("t2_rdaddr", {21'b0, ra[k+1]}, wexp[k]);
    chk("t2_eop_cycle", p_eop, 10);

    // single byte packet
    play(5, 1, 0, 0);
    chk("t3_eop_cycle", p_eop, 3);
    chk("t3_byte", {23'b0, p_lasts, p_lastb}, {23'b0, 1'b1, 8'h05});
    chk("t3_done_cycle", p_done, 4);
    chk("t3_idle_cycle", p_idle, 17);

    reject(0);
    reject(2049);

    // random backpressure with periodic 5-cycle stalls
    b0 = beats;
    play(400, 32, 1, 0);
    chk("t4_beats", beats - b0, 32);
    chk("t4_queue_empty", expq.size(), 0);

    // reset in the middle of a 40-byte packet
    b0 = beats;
    d0 = done_cnt;
    send(200, 40, 1);
    for (int w = 0; w < 100 && beats - b0 < 10; w++) @(negedge clock);
    chk("t5_reached_byte10", {31'b0, beats - b0 >= 10}, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    expq.delete();
    @(negedge clock);
    chk("t5_valid_after_reset", {31'b0, out_valid}, 0);
    repeat (20) begin
      @(negedge clock);
      chk("t5_quiet", {29'b0, out_valid, out_eop, busy}, 0);
    end
    chk("t5_no_done", done_cnt, d0);
    play(100, 4, 0, 0);
    chk("t5_next_eop_cycle", p_eop, 6);
    chk("t5_next_last_byte", {24'b0, p_lastb}, 8'((103 * 13 + 7) % 256));

    // start pulses during READ and during GAP
    play(300, 20, 0, 2);
    chk("t6_eop_cycle", p_eop, 22);
    chk("t6_idle_cycle", p_idle, 36);
    repeat (10) begin
      @(negedge clock);
      chk("t6_quiet", {30'b0, out_valid, busy}, 0);
    end
    chk("t6_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_pkt_reader.md
Name: rx_pkt_reader

Overview:
- Read side of the PHY-emulator 2Kx8 RX packet buffer.
- On a start command it fetches `pkt_len` bytes from the dual-port RAM read port, beginning at `start_addr` and wrapping modulo depth.
- It streams the bytes to the MAC RX datapath as a byte stream with `valid`/`ready`, `sop` and `eop`.
- After each packet it enforces a programmable inter-frame gap.
- The packet generator/testbench writes packets into the RAM; this block replays them.

Parameters:
- `DATAWIDTH`, 8, byte width of RAM and output stream.
- `ADDRWIDTH`, 11, RAM address width.
- `ADDRDEPTH`, 2048, RAM depth in bytes.
- `IFG_CYCLES`, 12, idle cycles enforced after each packet's eop handshake (0 allowed).

Ports:
- `clock`  in  1  single clock for the block and the RAM read port.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `start_addr`  in  ADDRWIDTH  first byte address of the packet.
- `pkt_len`  in  ADDRWIDTH+1  packet length in bytes; valid range 1..ADDRDEPTH.
- `rdaddress`  out  ADDRWIDTH  RAM read address; registered.
- `q`  in  DATAWIDTH  RAM read data; valid one cycle after `rdaddress`.
- `out_data`  out  DATAWIDTH  stream byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_sop`  out  1  first byte of packet; qualified by `out_valid`.
- `out_eop`  out  1  last byte of packet; qualified by `out_valid`.
- `out_ready`  in  1  sink accepts the byte when `out_valid && out_ready`.
- `busy`  out  1  high from accepted start until the gap expires.
- `done`  out  1  one-cycle pulse at packet completion or rejection.
- `err`  out  1  one-cycle pulse, coincident with `done`, for a rejected command.

Behaviour:
- Reset values: `rdaddress=0`, `out_valid=0`, `out_sop=0`, `out_eop=0`, `out_data=0`, `busy=0`, `done=0`, `err=0`.
- Reset clears the FSM, counters, in-flight flag and skid FIFO.
- Reset mid-packet aborts the packet with no eop and no done; `out_valid` is 0 in the cycle after reset is sampled.
- FSM states: IDLE, READ, DRAIN, GAP.
- IDLE:
  - `start` with `pkt_len` in 1..ADDRDEPTH: latch the address, load `rd_remaining=pkt_len` and `out_remaining=pkt_len`, set `busy`, go to READ.
  - `start` with `pkt_len=0` or `pkt_len>ADDRDEPTH`: pulse `done` and `err` next cycle, no output, stay IDLE; `busy` stays 0.
- A `start` seen in READ, DRAIN or GAP is ignored, with no side effects.
- Read issue:
  - A read issues in a cycle when READ, `rd_remaining>0`, and `fifo_occ + inflight < 3`.
  - On issue: `rdaddress` advances by +1 modulo ADDRDEPTH (2047 -> 0), `rd_remaining` decrements, and the in-flight flag is set for the next cycle.
  - RAM data `q` is written into a 3-entry skid FIFO one cycle after issue.
- Stream output:
  - The head of the FIFO drives `out_data`/`out_valid`.
  - `out_sop` is high on the first byte of the packet.
  - `out_eop` is high when `out_remaining==1`.
  - `out_remaining` decrements on each handshake.
  - Data, sop and eop are held stable while `out_valid && !out_ready`.
- Latency: with `out_ready` high, start is sampled at cycle 0, `rdaddress=start_addr` in cycle 1, and the first byte is valid in cycle 3. Throughput is then 1 byte/cycle.
- With `pkt_len=1`, `out_sop` and `out_eop` are asserted on the same byte.
- READ -> DRAIN when `rd_remaining` reaches 0.
- DRAIN -> GAP on the eop handshake. `done` pulses in the following cycle and the gap counter loads IFG_CYCLES.
- GAP:
  - The counter decrements each cycle.
  - At 0 -> IDLE and `busy` drops.
  - With `IFG_CYCLES=0`, GAP lasts one cycle.
- Backpressure: the FIFO never overflows, since at most 3 bytes are outstanding.
- Simultaneous FIFO push and pop in the same cycle keeps the occupancy unchanged.
- Wrap-around: `start_addr=2040`, `pkt_len=16` reads 2040..2047 then 0..7.

Decomposition:
- Shared package `rx_pkt_reader_pkg` holds:
  - the state enum (IDLE, READ, DRAIN, GAP);
  - the constant SKID_DEPTH=3;
  - error/status code constants shared with the packet generator.
- One sub-module, `rx_pkt_skid_fifo`, holds:
  - a 3-entry register FIFO of {data, sop, eop};
  - push/pop interfaces;
  - an occupancy output.
- All address, length and gap control stays in the top level.

Test Plan:
- Preload RAM 0..63 with `data=addr`. Send `start_addr=0`, `pkt_len=64` with `out_ready=1`.
  - Required: bytes 0x00..0x3F on consecutive cycles, the first in cycle 3.
  - Required: sop on 0x00, eop on 0x3F, `done` one cycle after eop, `busy` low IFG_CYCLES+1 cycles later.
- Send `start_addr=2044`, `pkt_len=8`.
  - Required: `rdaddress` sequence 2044, 2045, 2046, 2047, 0, 1, 2, 3; output bytes match the RAM contents in that order.
- Send `pkt_len=1` at addr 5.
  - Required: a single beat with sop=eop=1 and `data=mem[5]`.
  - Then send `pkt_len=0` and, separately, `pkt_len=2049`. Required: each gives a `done`+`err` pulse, no `out_valid`, `busy` stays 0.
- Send a 32-byte packet while `out_ready` toggles randomly (including 5-cycle stalls).
  - Required: no lost or duplicated bytes, data/sop/eop stable during stalls, byte order preserved.
- Assert `reset` at byte 10 of a 40-byte packet.
  - Required: `out_valid=0` next cycle, no eop and no done pulse.
  - A following `start` (addr 100, len 4) plays correctly from its sop.
- Pulse `start` during READ and during GAP.
  - Required: ignored, and the current packet is unaffected.
